// File: rtl/operand_entry_seq_pkg.sv
// Shared types and defaults for the operand entry sequencer and its button front-end.
package seq_pkg;

  typedef enum logic [1:0] {
    S_OP1    = 2'd0,
    S_OP2    = 2'd1,
    S_OPCODE = 2'd2,
    S_SHOW   = 2'd3
  } seq_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned TIMEOUT_CYCLES_DEF  = 500_000_000;

  // Width of a counter that must hold 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/operand_entry_seq_if.sv
// Button input and load-pulse / status outputs of the operand entry sequencer.
interface operand_entry_seq_if;
  import seq_pkg::*;

  logic       BTNC;
  logic       r0;
  logic       r1;
  logic       r2;
  seq_state_t stage;
  logic       result_valid;

  modport master (input BTNC, output r0, output r1, output r2, output stage, output result_valid);
  modport slave  (output BTNC, input r0, input r1, input r2, input stage, input result_valid);

endinterface

// File: rtl/operand_entry_seq_debounce.sv
// Reusable push-button front-end: 2-flop synchroniser, stability-counter debounce, rising-edge press.
module btn_debounce
  import seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic          armed;
  logic [1:0]    sync_valid;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      armed      <= 1'b0;
      sync_valid <= '0;
      cnt        <= '0;
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      sync_valid <= {sync_valid[0], 1'b1};
      level_d    <= level;
      // A button still held through reset must be released before it can press again.
      if (sync_valid[1] && !sync2)
        armed <= 1'b1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d & armed;

endmodule

// File: rtl/operand_entry_seq.sv
// Operand entry sequencer: each debounced BTNC press steps OP1 -> OP2 -> OpCode -> show.
// Optional idle timeout back to S_OP1 is enabled by defining SEQ_TIMEOUT_EN.
module operand_entry_seq
  import seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input logic                  CLK100MHZ,
  input logic                  CPU_RESETN,
  operand_entry_seq_if.master  bus
);

  seq_state_t state;
  logic       press;
  logic       level_unused;
  logic       r0;
  logic       r1;
  logic       r2;
  logic       result_valid;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .btn_raw   (bus.BTNC),
    .level     (level_unused),
    .press     (press)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned IW = cnt_width(TIMEOUT_CYCLES);
  logic [IW-1:0] idle;
`else
  localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state        <= S_OP1;
      r0           <= 1'b0;
      r1           <= 1'b0;
      r2           <= 1'b0;
      result_valid <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      idle         <= '0;
`endif
    end else begin
      r0 <= 1'b0;
      r1 <= 1'b0;
      r2 <= 1'b0;
      if (press) begin
`ifdef SEQ_TIMEOUT_EN
        idle <= '0;
`endif
        unique case (state)
          S_OP1:    begin state <= S_OP2;    r0 <= 1'b1; end
          S_OP2:    begin state <= S_OPCODE; r1 <= 1'b1; end
          S_OPCODE: begin state <= S_SHOW;   r2 <= 1'b1; result_valid <= 1'b1; end
          S_SHOW:   begin state <= S_OP1;    result_valid <= 1'b0; end
        endcase
      end
`ifdef SEQ_TIMEOUT_EN
      // Press has priority: the timeout only acts on cycles without one.
      else if (state == S_OP2 || state == S_OPCODE) begin
        if (idle == IW'(TIMEOUT_CYCLES - 1)) begin
          state <= S_OP1;
          idle  <= '0;
        end else begin
          idle <= idle + 1'b1;
        end
      end else begin
        idle <= '0;
      end
`endif
    end
  end

  assign bus.r0           = r0;
  assign bus.r1           = r1;
  assign bus.r2           = r2;
  assign bus.stage        = state;
  assign bus.result_valid = result_valid;

endmodule

// File: doc/operand_entry_seq.md
Name: operand_entry_seq

Overview:
Upstream control stage for the ALU operand register bank. Takes one raw push-button (BTNC), then synchronises, debounces and edge-detects it. Each accepted press steps a 4-state entry sequence that emits one-cycle load pulses r0 (OP1), r1 (OP2) and r2 (OpCode), so the bank captures SW in order. Also drives a stage indicator for LEDs/7-seg and a result-valid flag for the downstream ALU display.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles the synchronised button must be stable before its level is accepted (10 ms at 100 MHz); minimum 2.
TIMEOUT_CYCLES, 500_000_000, idle cycles before abandoning a partial entry (5 s); used only with SEQ_TIMEOUT_EN.

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  reset, synchronous, active-low
BTNC  in  1  raw asynchronous "enter" button, active-high
r0  out  1  one-cycle load pulse for the OP1 register
r1  out  1  one-cycle load pulse for the OP2 register
r2  out  1  one-cycle load pulse for the OpCode register
stage  out  2  current state encoding (seq_state_t)
result_valid  out  1  high while all three values are loaded

Behaviour:
- Clocking and reset: one clock, CLK100MHZ. Reset is synchronous, active-low. While CPU_RESETN=0 at a rising edge:
  - r0=r1=r2=0, result_valid=0, stage=S_OP1.
  - Sync flops, debounce counter and stable level clear to 0.
  - Reset applied mid-sequence abandons the entry. No pulse is emitted on the reset cycle or on the cycle after it.
- Synchroniser: 2-flop chain on BTNC. Raw BTNC is never used elsewhere.
- Debounce:
  - The counter clears whenever the synchronised level equals the stable level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronised level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge detect: press = stable rises 0->1, one cycle wide. Release produces nothing. A held button produces exactly one press.
- Latency: the registered pulse (r0/r1/r2) and the stage update occur on the cycle after the stable level rises. From a clean BTNC rising edge this totals 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- FSM (seq_state_t), transitions on press only:
  - S_OP1 --press--> S_OP2, r0=1 for 1 cycle
  - S_OP2 --press--> S_OPCODE, r1=1 for 1 cycle
  - S_OPCODE --press--> S_SHOW, r2=1 for 1 cycle
  - S_SHOW --press--> S_OP1, no pulse; result_valid falls in the same cycle the state leaves S_SHOW
- Pulse and flag rules:
  - At most one of r0/r1/r2 is high in any cycle. All are 0 when there is no press.
  - result_valid = (state == S_SHOW), registered. It rises on the same edge that r2 pulses, so the bank holds OpCode one cycle later. The consumer ignores the first valid cycle or registers its own output.
- SW is not an input here. Value capture is entirely the bank's job.

Optional Feature:
Macro SEQ_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every press and in S_OP1/S_SHOW. It counts in S_OP2/S_OPCODE.
  - On reaching TIMEOUT_CYCLES-1, state returns to S_OP1 with no pulse and the counter clears.
  - A press in the same cycle as the timeout wins: the normal transition is taken.
- Undefined: no idle counter. Partial entries persist indefinitely; TIMEOUT_CYCLES is ignored.

Decomposition:
- Package seq_pkg:
  - typedef enum logic [1:0] seq_state_t {S_OP1=2'd0, S_OP2=2'd1, S_OPCODE=2'd2, S_SHOW=2'd3}.
  - Localparams DEBOUNCE_CYCLES_DEF and TIMEOUT_CYCLES_DEF.
  - Function clog2-based width helper for the counters.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES; ports CLK100MHZ, CPU_RESETN, btn_raw, level, press): holds the synchroniser, counter and edge detector. It is reused later for other buttons.
- The top level contains the FSM and the optional timeout.

Test Plan (sim with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50):
- Reset then idle: CPU_RESETN=0 for 3 cycles, BTNC=0 -> stage=0, r0..r2=0, result_valid=0 throughout.
- Clean press: BTNC 0->1 held 20 cycles after reset -> exactly one r0 pulse 7 cycles after the rise (2 sync + 4 debounce + 1), then stage=1. Release gives no pulse.
- Full sequence: four clean presses -> r0, r1, r2 pulses in that order, one cycle each. Stage goes 0,1,2,3,0. result_valid is high only while stage=3.
- Bounce: BTNC toggles 1,0,1,0 each for 2 cycles, then steady 1 -> a single r pulse only after 4 stable cycles; no pulse from the glitches.
- Reset mid-op: at stage=2 with BTNC stable high, assert CPU_RESETN=0 for 1 cycle -> stage=0, no r pulse. The held button yields no press until released and pressed again.
- SEQ_TIMEOUT_EN: reach stage=1 and wait 50 cycles with no press -> stage=0, no pulses. With the macro undefined -> still stage=1 after 200 cycles.
